uart_tx_controller: RTL and testbench

Frame sequencer for the UART transmit path. It accepts a byte from the host, freezes the baud configuration for the sampler, and restarts the sampler so frame timing is phase-aligned. It then counts the sampler's `sample_ENABLE` ticks to shift out a start bit, 8 data bits (LSB first), an optional parity bit and a stop bit on `TxD`. It sits between the host write port and the baud-rate sampler, and is the only block allowed to drive the sampler's `baud_select` and clear.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_tx_controller.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, baud rate codes and data width.
// Used by the transmit controller and the bit timer (and the future receiver).
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Transmit sequencer states. PARITY is only reachable when UART_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Rate codes understood by the baud-rate sampler.
  localparam logic [2:0] BAUD_300    = 3'd0;
  localparam logic [2:0] BAUD_1200   = 3'd1;
  localparam logic [2:0] BAUD_2400   = 3'd2;
  localparam logic [2:0] BAUD_4800   = 3'd3;
  localparam logic [2:0] BAUD_9600   = 3'd4;
  localparam logic [2:0] BAUD_19200  = 3'd5;
  localparam logic [2:0] BAUD_38400  = 3'd6;
  localparam logic [2:0] BAUD_115200 = 3'd7;

  // Even parity bit: XOR of all data bits, so the total count of ones is even.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts sampler ticks modulo OVERSAMPLE and flags the tick
// that closes a bit period. Shared between the transmit and receive paths.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,    // restart the bit period (has priority over tick_i)
  input  logic tick_i,     // one-cycle sampler tick, already qualified by the caller
  output logic bit_end_o   // high on the tick that completes the current bit
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end_o = tick_i && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance on a tick and wrap at the last tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Tick counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit frame sequencer. Accepts a byte from the host, freezes the baud
// code for the sampler, restarts the sampler and shifts out start, 8 data bits
// (LSB first), optional even parity and stop on TxD.
// Optional feature macro: UART_PARITY_EN (adds the parity bit, 11-bit frame).
//
// Handshake: Tx_WR is a single-cycle valid strobe carrying Tx_DATA and
// baud_select. The block is ready when Tx_EN is high and Tx_BUSY is low
// (Tx_BUSY low exactly when the FSM is IDLE). A strobe that arrives while not
// ready is dropped, not held; the host must retry after Tx_BUSY falls.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                   clk,
  input  logic                   reset,          // asynchronous, active low
  input  logic                   Tx_EN,
  input  logic                   Tx_WR,
  input  logic [UART_DATA_W-1:0] Tx_DATA,
  input  logic [2:0]             baud_select,
  input  logic                   sample_ENABLE,
  output logic [2:0]             baud_select_q,
  output logic                   sampler_clear,
  output logic                   TxD,
  output logic                   Tx_BUSY,
  output tx_state_t              dbg_state_o     // FSM state for observation
);

  tx_state_t              state_q, state_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [2:0]             rate_q, rate_d;
  logic                   txd_q, txd_d;
  logic                   busy_q, busy_d;
`ifdef UART_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic accept;
  logic timer_tick;
  logic bit_end;

  // Reset gates accept so sampler_clear is forced low while reset is asserted.
  assign accept        = Tx_WR && Tx_EN && (state_q == IDLE) && reset;
  assign sampler_clear = accept;
  // Ticks only count inside a frame; the accept-cycle tick is thus ignored.
  assign timer_tick    = sample_ENABLE && (state_q != IDLE);

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clear_i   (accept),
    .tick_i    (timer_tick),
    .bit_end_o (bit_end)
  );

  // Next-state logic: frame sequencing, latching on accept, shifting at bit ends.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rate_d    = rate_q;
`ifdef UART_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = Tx_DATA;
          rate_d    = baud_select;
          bit_cnt_d = '0;
`ifdef UART_PARITY_EN
          parity_d  = even_parity(Tx_DATA);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[UART_DATA_W-1:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
`ifdef UART_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line and busy values for the next cycle, derived from the next state so
  // the registered outputs line up with the state they describe.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_PARITY_EN
      PARITY:  txd_d = parity_q;
`endif
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset puts the line at idle mark.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rate_q    <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rate_q    <= rate_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
    end
  end

`ifdef UART_PARITY_EN
  // Parity of the latched byte, captured at accept since the shifter is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign baud_select_q = rate_q;
  assign TxD           = txd_q;
  assign Tx_BUSY       = busy_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller with OVERSAMPLE=16. Builds with or
// without UART_PARITY_EN; expected frames are hand-written for both.
`timescale 1ns/1ps
module tb_uart_tx_controller;
  import uart_pkg::*;

  localparam int OS = 16;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
  localparam logic [10:0] F_A5 = 11'b10101001010;
  localparam logic [10:0] F_07 = 11'b11000001110;
  localparam logic [10:0] F_00 = 11'b10000000000;
  localparam logic [10:0] F_FF = 11'b10111111110;
  localparam logic [10:0] F_01 = 11'b11000000010;
  localparam logic [10:0] F_3C = 11'b10001111000;
`else
  localparam int FB = 10;
  localparam logic [10:0] F_A5 = 11'b01101001010;
  localparam logic [10:0] F_07 = 11'b01000001110;
  localparam logic [10:0] F_00 = 11'b01000000000;
  localparam logic [10:0] F_FF = 11'b01111111110;
  localparam logic [10:0] F_01 = 11'b01000000010;
  localparam logic [10:0] F_3C = 11'b01001111000;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en, tx_wr, samp;
  logic [7:0] tx_data;
  logic [2:0] baud;
  logic [2:0] baud_q;
  logic       sampler_clear, txd, tx_busy;
  tx_state_t  dbg_state;

  always #5 clk = ~clk;

  uart_tx_controller #(.OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .reset         (reset),
    .Tx_EN         (tx_en),
    .Tx_WR         (tx_wr),
    .Tx_DATA       (tx_data),
    .baud_select   (baud),
    .sample_ENABLE (samp),
    .baud_select_q (baud_q),
    .sampler_clear (sampler_clear),
    .TxD           (txd),
    .Tx_BUSY       (tx_busy),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_frame(input logic [10:0] act);
    logic [0:0] e;
    for (int i = 0; i < FB; i++) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL frame_bit: expected queue empty at bit %0d", i);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("frame_bit%0d", i), act[i], e);
      end
    end
  endtask

  // Monitor: counts sampler_clear cycles and the length of each Tx_BUSY-low gap.
  int clr_cnt  = 0;
  int gap_run  = 0;
  int last_gap = -1;
  always @(negedge clk) begin
    #3;
    if (sampler_clear === 1'b1) clr_cnt++;
    if (tx_busy === 1'b0) begin
      gap_run++;
    end else begin
      if (gap_run > 0) last_gap = gap_run;
      gap_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  // Drives one write strobe, checks the accept pulse and START entry, and
  // queues the expected frame bits.
  task automatic accept_byte(input logic [7:0] d, input logic [2:0] b, input logic tk,
                             input logic [10:0] frame, input logic keep_wr);
    @(negedge clk);
    tx_en = 1'b1; tx_wr = 1'b1; tx_data = d; baud = b; samp = tk;
    #2;
    check("accept_clear", sampler_clear, 1'b1);
    for (int i = 0; i < FB; i++) exp_q.push_back(frame[i]);
    @(negedge clk);
    if (!keep_wr) tx_wr = 1'b0;
    samp = 1'b0;
    #2;
    check("busy_rise", tx_busy, 1'b1);
    check("start_txd", txd, 1'b0);
    check("baud_q", baud_q, b);
  endtask

  // Issues ticks (one tick cycle + one gap cycle) while Tx_BUSY is high,
  // recording the line value of each bit period. Optional events: a stray
  // write after tick wr_at, dropping Tx_EN after tick drop_at, stopping early.
  task automatic run_frame(input int stop_at, input int wr_at, input int drop_at,
                           output int ticks, output logic [10:0] act);
    logic cur;
    logic glitch;
    int   k;
    k = 0; act = '0; cur = 1'b1; glitch = 1'b0;
    while (tx_busy === 1'b1 && k < 400 && k != stop_at) begin
      @(negedge clk);
      samp = 1'b1;
      if (wr_at >= 0 && k == wr_at + 1) tx_wr = 1'b0;
      #2;
      if (k % OS == 0) begin
        cur = txd; glitch = 1'b0;
      end else if (txd !== cur) begin
        glitch = 1'b1;
      end
      if (k % OS == OS - 1) begin
        if (k / OS < 11) act[k / OS] = cur;
        check("bit_stable", glitch, 1'b0);
      end
      @(negedge clk);
      samp = 1'b0;
      if (k == wr_at) begin
        tx_wr = 1'b1; tx_en = 1'b1; tx_data = 8'hFF; baud = 3'd2;
      end
      if (k == drop_at) tx_en = 1'b0;
      #2;
      if (k == wr_at) check("busy_wr_clear", sampler_clear, 1'b0);
      k++;
    end
    ticks = k;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  data;
    logic [2:0]  baud;
    logic        tick_acc;   // sample_ENABLE asserted in the accept cycle
    logic [10:0] frame;      // expected line bits, bit 0 = start bit
  } vec_t;

  localparam int NV = 5;
  vec_t vecs[NV];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          ticks, ticks1, c0;
    logic [10:0] act, act1;

    vecs[0] = '{8'hA5, 3'd7, 1'b0, F_A5};
    vecs[1] = '{8'h07, 3'd1, 1'b1, F_07};
    vecs[2] = '{8'h00, 3'd0, 1'b0, F_00};
    vecs[3] = '{8'hFF, 3'd4, 1'b1, F_FF};
    vecs[4] = '{8'h01, 3'd6, 1'b0, F_01};

    // Reset with a write strobe present: nothing may leak through.
    reset = 1'b0; tx_en = 1'b1; tx_wr = 1'b1; tx_data = 8'h55; baud = 3'd5; samp = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_txd", txd, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_baud_q", baud_q, 3'd0);
    check("rst_clear", sampler_clear, 1'b0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk);
    tx_wr = 1'b0; tx_en = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames.
    for (int i = 0; i < NV; i++) begin
      c0 = clr_cnt;
      accept_byte(vecs[i].data, vecs[i].baud, vecs[i].tick_acc, vecs[i].frame, 1'b0);
      run_frame(-1, -1, -1, ticks, act);
      check("busy_ticks", ticks, FB * OS);
      check("idle_txd", txd, 1'b1);
      check("idle_state", dbg_state, IDLE);
      compare_frame(act);
      check("clear_pulses", clr_cnt - c0, 1);
      repeat (2) @(negedge clk);
    end

    // Stray write (FF, rate 2) at tick 50 while busy: ignored.
    c0 = clr_cnt;
    accept_byte(8'hA5, 3'd7, 1'b0, F_A5, 1'b0);
    run_frame(-1, 50, -1, ticks, act);
    check("wr_busy_ticks", ticks, FB * OS);
    check("wr_busy_baud_q", baud_q, 3'd7);
    compare_frame(act);
    check("wr_busy_clears", clr_cnt - c0, 1);
    repeat (2) @(negedge clk);

    // Write with Tx_EN low: no accept.
    c0 = clr_cnt;
    tx_en = 1'b0; tx_wr = 1'b1; tx_data = 8'h3C; baud = 3'd3;
    #2;
    check("en_low_clear", sampler_clear, 1'b0);
    @(negedge clk);
    tx_wr = 1'b0;
    #2;
    check("en_low_txd", txd, 1'b1);
    check("en_low_busy", tx_busy, 1'b0);
    check("en_low_clears", clr_cnt - c0, 0);
    @(negedge clk);

    // Tx_EN dropped at tick 30: frame still completes.
    accept_byte(8'h07, 3'd2, 1'b0, F_07, 1'b0);
    run_frame(-1, -1, 30, ticks, act);
    check("en_drop_ticks", ticks, FB * OS);
    compare_frame(act);
    check("en_drop_txd", txd, 1'b1);
    repeat (2) @(negedge clk);

    // Back-to-back: Tx_WR held high across two frames.
    c0 = clr_cnt;
    accept_byte(8'h3C, 3'd5, 1'b0, F_3C, 1'b1);
    run_frame(-1, -1, -1, ticks1, act1);
    for (int i = 0; i < FB; i++) exp_q.push_back(F_3C[i]);
    @(negedge clk);
    #2;
    check("b2b_busy", tx_busy, 1'b1);
    check("b2b_start_txd", txd, 1'b0);
    tx_wr = 1'b0;
    run_frame(-1, -1, -1, ticks, act);
    check("b2b_ticks1", ticks1, FB * OS);
    check("b2b_ticks2", ticks, FB * OS);
    compare_frame(act1);
    compare_frame(act);
    check("b2b_clears", clr_cnt - c0, 2);
    check("b2b_gap", last_gap, 1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a frame of zeros, then a fresh frame.
    accept_byte(8'h00, 3'd3, 1'b0, F_00, 1'b0);
    run_frame(40, -1, -1, ticks, act);
    check("mid_txd_low", txd, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_txd", txd, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    check("mid_rst_baud_q", baud_q, 3'd0);
    check("mid_rst_state", dbg_state, IDLE);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    c0 = clr_cnt;
    accept_byte(8'hA5, 3'd7, 1'b0, F_A5, 1'b0);
    run_frame(-1, -1, -1, ticks, act);
    check("post_rst_ticks", ticks, FB * OS);
    compare_frame(act);
    check("post_rst_clears", clr_cnt - c0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
